// File: rtl/per_rx_fifo.sv
// Receive FIFO behind the peripheral SEND/DATA link input: queues link words, hands them to the
// core through a first-word-fall-through valid/ready port, and reports per-word ACK and sticky overflow.
module per_rx_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk_per,
  input  logic              rst_per,
  input  logic              SEND_per,
  input  logic [DATA_W-1:0] inputData_per,
  output logic              outACK_per,
  output logic              outOVF_per,
  output logic [DATA_W-1:0] outDATA_per,
  output logic              outVALID_per,
  input  logic              inREADY_per,
  output logic [ADDR_W:0]   outCOUNT_per
);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } fifoState_t;

  localparam logic [ADDR_W:0]   CNT_ZERO = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   CNT_LAST = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [ADDR_W-1:0] wrPtr_r;
  logic [ADDR_W-1:0] rdPtr_r;
  logic [ADDR_W:0]   count_r;
  logic [ADDR_W:0]   countNext_s;
  fifoState_t        state_r;
  fifoState_t        stateNext_s;
  logic              pop_s;
  logic              push_s;
  logic              drop_s;
  logic              ackR_r;
  logic              ovf_r;

  // A full FIFO still takes a word when the head leaves in the same cycle, hence READY feeds push.
  assign pop_s  = outVALID_per & inREADY_per;
  assign push_s = SEND_per & ((state_r != FULL) | pop_s);
  assign drop_s = SEND_per & (state_r == FULL) & ~pop_s;

  assign outDATA_per  = mem_r[rdPtr_r];
  assign outVALID_per = (count_r != CNT_ZERO);
  assign outCOUNT_per = count_r;
  assign outACK_per   = ackR_r;
  assign outOVF_per   = ovf_r;

  // Occupancy arithmetic: simultaneous push and pop leave the count unchanged.
  always_comb begin
    countNext_s = count_r;
    case ({push_s, pop_s})
      2'b10:   countNext_s = count_r + CNT_ONE;
      2'b01:   countNext_s = count_r - CNT_ONE;
      default: countNext_s = count_r;
    endcase
  end

  // Fill-level state tracking; only push-only or pop-only cycles move between levels.
  always_comb begin
    stateNext_s = state_r;
    case (state_r)
      EMPTY: begin
        if (push_s) begin
          stateNext_s = PARTIAL;
        end else begin
          stateNext_s = EMPTY;
        end
      end
      PARTIAL: begin
        if (push_s && !pop_s && (count_r == CNT_LAST)) begin
          stateNext_s = FULL;
        end else if (pop_s && !push_s && (count_r == CNT_ONE)) begin
          stateNext_s = EMPTY;
        end else begin
          stateNext_s = PARTIAL;
        end
      end
      FULL: begin
        if (pop_s && !push_s) begin
          stateNext_s = PARTIAL;
        end else begin
          stateNext_s = FULL;
        end
      end
      default: stateNext_s = EMPTY;
    endcase
  end

  // Storage, pointers and link status; reset overrides any push or pop in the same cycle.
  always_ff @(posedge clk_per) begin
    if (rst_per) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DATA_W{1'b0}};
      end
      wrPtr_r <= {ADDR_W{1'b0}};
      rdPtr_r <= {ADDR_W{1'b0}};
      count_r <= CNT_ZERO;
      state_r <= EMPTY;
      ackR_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      if (push_s) begin
        mem_r[wrPtr_r] <= inputData_per;
        wrPtr_r        <= wrPtr_r + PTR_ONE;
      end
      if (pop_s) begin
        rdPtr_r <= rdPtr_r + PTR_ONE;
      end
      count_r <= countNext_s;
      state_r <= stateNext_s;
      ackR_r  <= push_s;
      if (drop_s) begin
        ovf_r <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_per_rx_fifo.sv
// Directed and randomized checks of per_rx_fifo against a queue-based model of the link FIFO.
module tb_per_rx_fifo;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 2;

  logic              clk_per = 1'b0;
  logic              rst_per = 1'b1;
  logic              SEND_per = 1'b0;
  logic [DATA_W-1:0] inputData_per = 32'h0000_0000;
  logic              outACK_per;
  logic              outOVF_per;
  logic [DATA_W-1:0] outDATA_per;
  logic              outVALID_per;
  logic              inREADY_per = 1'b0;
  logic [ADDR_W:0]   outCOUNT_per;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] modelQ[$];
  logic [DATA_W-1:0] consumed[$];
  logic              modelOvf = 1'b0;
  logic              modelAck = 1'b0;

  per_rx_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk_per(clk_per), .rst_per(rst_per), .SEND_per(SEND_per),
    .inputData_per(inputData_per), .outACK_per(outACK_per), .outOVF_per(outOVF_per),
    .outDATA_per(outDATA_per), .outVALID_per(outVALID_per), .inREADY_per(inREADY_per),
    .outCOUNT_per(outCOUNT_per)
  );

  always #5 clk_per = ~clk_per;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare every visible output with the model right after an edge.
  task automatic checkState(input string tag);
    chk({tag, ".count"}, 32'(outCOUNT_per), 32'(modelQ.size()));
    chk({tag, ".valid"}, 32'(outVALID_per), 32'(modelQ.size() != 0));
    chk({tag, ".ack"},   32'(outACK_per),   32'(modelAck));
    chk({tag, ".ovf"},   32'(outOVF_per),   32'(modelOvf));
    if (modelQ.size() != 0) chk({tag, ".head"}, outDATA_per, modelQ[0]);
  endtask

  // One clock with given link/consumer inputs; model evaluated from the pre-edge contents.
  task automatic cycle(input logic send, input logic [DATA_W-1:0] data, input logic ready,
                       input string tag);
    logic pop, push;
    SEND_per = send;
    inputData_per = data;
    inREADY_per = ready;
    rst_per = 1'b0;
    pop  = ready && (modelQ.size() != 0);
    push = send && ((modelQ.size() < DEPTH) || pop);
    if (pop) begin
      chk({tag, ".popdata"}, outDATA_per, modelQ[0]);
      consumed.push_back(modelQ[0]);
      void'(modelQ.pop_front());
    end
    if (push) modelQ.push_back(data);
    if (send && !push) modelOvf = 1'b1;
    modelAck = push;
    @(posedge clk_per);
    #1;
    checkState(tag);
  endtask

  task automatic doReset(input int n, input string tag);
    rst_per = 1'b1;
    SEND_per = 1'b1;
    inputData_per = 32'hA5A5_A5A5;
    inREADY_per = 1'b1;
    modelQ.delete();
    modelOvf = 1'b0;
    modelAck = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk_per);
      #1;
      checkState(tag);
      chk({tag, ".data0"}, outDATA_per, 32'h0000_0000);
    end
    rst_per = 1'b0;
    SEND_per = 1'b0;
    inREADY_per = 1'b0;
  endtask

  initial begin
    // T1: reset held with SEND asserted
    doReset(3, "T1");

    // T2: single word
    cycle(1'b1, 32'hDEAD_BEEF, 1'b0, "T2push");
    chk("T2.ackExact", 32'(outACK_per), 32'h1);
    chk("T2.headExact", outDATA_per, 32'hDEAD_BEEF);
    cycle(1'b0, 32'h0, 1'b0, "T2idle");

    // T3: fill and overflow
    doReset(1, "T3rst");
    for (int i = 1; i <= 5; i++) cycle(1'b1, 32'(i), 1'b0, "T3fill");
    chk("T3.countExact", 32'(outCOUNT_per), 32'd4);
    chk("T3.ovfExact", 32'(outOVF_per), 32'h1);
    chk("T3.headExact", outDATA_per, 32'd1);
    chk("T3.noAck5", 32'(outACK_per), 32'h0);

    // T4: full FIFO accepts with simultaneous pop
    cycle(1'b1, 32'd6, 1'b1, "T4");
    chk("T4.headExact", outDATA_per, 32'd2);
    chk("T4.ackExact", 32'(outACK_per), 32'h1);

    // T5: streaming through wrap-around
    doReset(1, "T5rst");
    consumed.delete();
    for (int i = 1; i <= 10; i++) begin
      cycle(1'b1, 32'(i), 1'b1, "T5");
      chk("T5.countLe1", 32'(outCOUNT_per <= 3'd1), 32'h1);
    end
    cycle(1'b0, 32'h0, 1'b1, "T5drain");
    chk("T5.nconsumed", 32'(consumed.size()), 32'd10);
    for (int i = 0; i < consumed.size(); i++) chk("T5.order", consumed[i], 32'(i + 1));
    chk("T5.noOvf", 32'(outOVF_per), 32'h0);

    // T6: reset in the middle of a stream
    for (int i = 1; i <= 4; i++) cycle(1'b1, 32'(100 + i), 1'b0, "T6fill");
    cycle(1'b1, 32'd200, 1'b0, "T6drop");
    doReset(1, "T6rst");
    cycle(1'b1, 32'd7, 1'b0, "T6push");
    chk("T6.head7", outDATA_per, 32'd7);
    cycle(1'b0, 32'h0, 1'b1, "T6pop");

    // Randomized traffic with occasional resets
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 49) == 0) begin
        doReset(1, "RNDrst");
      end else begin
        cycle(1'($urandom_range(0, 2) != 0), $urandom, 1'($urandom_range(0, 2) == 0), "RND");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
